// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array controllers: FSM state encoding,
// index width helper and the default flush window, so the load and drain
// controllers agree on grid timing.
package systolic_pkg;

   // One-hot controller states, registered directly as the state vector.
   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_FLUSH = 4'b0010,
      ST_DRAIN = 4'b0100,
      ST_CLEAR = 4'b1000
   } drain_state_e;

   // Row/column select width; at least one bit even for a 1x1 grid.
   function automatic int idx_w(input int size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

   // MAC cycles needed for the last skewed partial to reach the far corner PE.
   function automatic int default_flush_len(input int size);
      return 2 * size - 1;
   endfunction

endpackage

// File: rtl/systolic_idx_counter.sv
// Row-major 2-D index counter: col advances on each enable, wrapping into
// the next row; wraps back to (0,0) after the last cell. last_o flags the
// final cell (row = col = SIZE-1).
module systolic_idx_counter #(
   parameter int SIZE  = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [IDX_W-1:0] row_o,
   output logic [IDX_W-1:0] col_o,
   output logic             last_o
);

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SIZE - 1);

   logic [IDX_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_q, col_d;

   // Next index: clear wins over enable; otherwise step in row-major order.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      row_d = row_q;
      col_d = col_q;
      if (clr_i) begin
         row_d = '0;
         col_d = '0;
      end else if (en_i) begin
         if (col_q == IDX_MAX) begin
            col_d = '0;
            row_d = (row_q == IDX_MAX) ? '0 : row_q + IDX_W'(1);
         end else begin
            col_d = col_q + IDX_W'(1);
         end
      end
   end

   // Index registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row_o  = row_q;
   assign col_o  = col_q;
   assign last_o = (row_q == IDX_MAX) && (col_q == IDX_MAX);

endmodule

// File: rtl/systolic_drain_ctrl.sv
// Result readout sequencer for the SIZE x SIZE PE grid: holds MAC enabled
// for the flush window, streams every accumulator in row-major order over
// a val/rdy interface, then clears the grid and pulses done.
module systolic_drain_ctrl
   import systolic_pkg::*;
#(
   parameter  int SIZE      = 4,
   parameter  int FLUSH_LEN = default_flush_len(SIZE),
   localparam int IDX_W     = idx_w(SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             mac_en,
   output logic [IDX_W-1:0] row_sel,
   output logic [IDX_W-1:0] col_sel,
   output logic             out_val,
   input  logic             out_rdy,
   output logic             out_last,
   output logic             acc_clr,
   output logic             busy,
   output logic             done
);

   localparam int              CNT_W      = $clog2(FLUSH_LEN + 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);

   drain_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_drain;
   logic             xfer;
   logic             idx_last;

   assign in_drain = (state_q == ST_DRAIN);
   // out_val is high for the whole drain, so a beat moves whenever rdy is high.
   assign xfer     = in_drain && out_rdy;

   // Indices run only while draining and are held at (0,0) elsewhere.
   systolic_idx_counter #(
      .SIZE  (SIZE),
      .IDX_W (IDX_W)
   ) u_idx (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (!in_drain),
      .en_i   (xfer),
      .row_o  (row_sel),
      .col_o  (col_sel),
      .last_o (idx_last)
   );

   // Next-state and flush-counter logic; start outside IDLE is dropped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == FLUSH_LAST) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (xfer && idx_last) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and flush counter registers; reset aborts any tile in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode registered state only, keeping out_rdy off every output path.
   assign mac_en   = (state_q == ST_FLUSH);
   assign out_val  = in_drain;
   assign out_last = in_drain && idx_last;
   assign acc_clr  = (state_q == ST_CLEAR);
   assign done     = (state_q == ST_CLEAR);
   assign busy     = (state_q == ST_FLUSH) || in_drain || (state_q == ST_CLEAR);

endmodule
